fb_stream_reader: RTL and testbench

- Read-side initiator for the single-port 8-bit frame-buffer RAM: `addr`, `write`, `ENABLE`, `out_data`, with a registered read of 1-cycle latency.
- Sweeps one WIDTH x HEIGHT frame in raster order, holding write low.
- Converts the RAM's fixed-latency reads into a valid/ready pixel stream with frame and line markers for downstream QoS/display logic.
- Issues reads on credits, so backpressure never loses a pixel.

---
 rtl/fb_pkg.sv | 26 ++
 rtl/fb_sync_fifo.sv | 77 +++++++
 rtl/fb_stream_reader.sv | 184 ++++++++++++++++++
 tb/tb_fb_stream_reader.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/fb_pkg.sv
// Shared types and constants for the frame-buffer stream reader.
// Defines FSM states, sideband tags, default sizes and credit width.
package fb_pkg;

  localparam int FB_WIDTH  = 320;
  localparam int FB_HEIGHT = 240;
  localparam int FB_PIXELS = FB_WIDTH * FB_HEIGHT;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2
  } fb_state_e;

  typedef struct packed {
    logic sof;
    logic eol;
    logic eof;
  } fb_tag_t;

  // Bits needed to hold any value in 0..depth.
  function automatic int credit_w(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/fb_sync_fifo.sv
// Synchronous FIFO, flop array, head presented straight from flops.
// Ports: CLOCK_50, RESET_N, push/wdata, pop/rdata, count, full, empty.
module fb_sync_fifo
  import fb_pkg::*;
#(
  parameter int DW    = 11,
  parameter int DEPTH = 4,
  localparam int AW   = $clog2(DEPTH),
  localparam int CW   = credit_w(DEPTH)
) (
  input  logic          CLOCK_50,
  input  logic          RESET_N,
  input  logic          push,
  input  logic [DW-1:0] wdata,
  input  logic          pop,
  output logic [DW-1:0] rdata,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty
);

  logic [DW-1:0] mem_q [DEPTH];
  logic [DW-1:0] mem_d [DEPTH];
  logic [AW-1:0] wr_q, wr_d;
  logic [AW-1:0] rd_q, rd_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          do_pop;

  assign do_pop = pop && !empty;

  always_comb begin
    mem_d = mem_q;
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (push) begin
      mem_d[wr_q] = wdata;
      wr_d        = wr_q + AW'(1);
    end
    if (do_pop) begin
      rd_d = rd_q + AW'(1);
    end
    unique case ({push, do_pop})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge CLOCK_50) begin
    if (!RESET_N) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      mem_q <= mem_d;
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  assign rdata = mem_q[rd_q];
  assign count = cnt_q;
  assign full  = (cnt_q == CW'(DEPTH));
  assign empty = (cnt_q == '0);

  // Upstream credit must prevent writes into a full FIFO.
  a_no_overflow: assert property (
    @(posedge CLOCK_50) disable iff (!RESET_N)
    !(push && full && !do_pop)
  );

endmodule

// File: rtl/fb_stream_reader.sv
// Raster-order frame-buffer reader: 1-cycle-latency RAM reads to a
// valid/ready pixel stream with sof/eol/eof. Credit-based issue.
// Ports: CLOCK_50, RESET_N, start/busy/done, mem_* RAM side,
// pix_* stream side. Macro FB_LOOP_EN selects continuous scanning.
module fb_stream_reader
  import fb_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 20,
  parameter int WIDTH      = FB_WIDTH,
  parameter int HEIGHT     = FB_HEIGHT,
  parameter int BASE_ADDR  = 0,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  CLOCK_50,
  input  logic                  RESET_N,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  mem_en,
  output logic                  mem_write,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic [DATA_WIDTH-1:0] pix_data,
  output logic                  pix_valid,
  input  logic                  pix_ready,
  output logic                  pix_sof,
  output logic                  pix_eol,
  output logic                  pix_eof
);

`ifdef FB_LOOP_EN
  localparam bit LOOP_EN = 1'b1;
`else
  localparam bit LOOP_EN = 1'b0;
`endif

  localparam int CRW = credit_w(FIFO_DEPTH);
  localparam int XW  = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int YW  = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
  localparam int FW  = DATA_WIDTH + 3;

  localparam logic [XW-1:0] X_LAST = XW'(WIDTH - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(HEIGHT - 1);
  localparam logic [ADDR_WIDTH-1:0] A_BASE =
    ADDR_WIDTH'(BASE_ADDR);

  fb_state_e             state_q, state_d;
  logic [XW-1:0]         col_q, col_d;
  logic [YW-1:0]         row_q, row_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  inflight_q, inflight_d;
  fb_tag_t               tag_q, tag_d;
  logic                  done_q, done_d;

  fb_tag_t               issue_tag;
  fb_tag_t               head_tag;
  logic [CRW-1:0]        fifo_count;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic [FW-1:0]         fifo_wdata;
  logic [FW-1:0]         fifo_rdata;
  logic                  credit_ok;
  logic                  issue;
  logic                  col_end;
  logic                  row_end;
  logic                  pop;
  logic                  last_out;

  // Reads in flight are counted against FIFO space before issuing.
  assign credit_ok = !fifo_full &&
    ((fifo_count + CRW'(inflight_q)) < CRW'(FIFO_DEPTH));
  assign issue   = (state_q == ISSUE) && credit_ok;
  assign col_end = (col_q == X_LAST);
  assign row_end = (row_q == Y_LAST);
  assign pop     = pix_valid && pix_ready;

  // Drain finishes on the edge that pops the final buffered pixel.
  assign last_out = !inflight_q &&
    (fifo_empty || ((fifo_count == CRW'(1)) && pop));

  always_comb begin
    issue_tag.sof = (col_q == '0) && (row_q == '0);
    issue_tag.eol = col_end;
    issue_tag.eof = col_end && row_end;
  end

  always_comb begin
    state_d    = state_q;
    col_d      = col_q;
    row_d      = row_q;
    addr_d     = addr_q;
    tag_d      = tag_q;
    done_d     = 1'b0;
    inflight_d = issue;
    if (issue) begin
      tag_d = issue_tag;
      if (col_end) begin
        col_d = '0;
        if (row_end) begin
          row_d  = '0;
          addr_d = A_BASE;
        end else begin
          row_d  = row_q + YW'(1);
          addr_d = addr_q + ADDR_WIDTH'(1);
        end
      end else begin
        col_d  = col_q + XW'(1);
        addr_d = addr_q + ADDR_WIDTH'(1);
      end
    end
    unique case (1'b1)
      (state_q == IDLE): begin
        if (start) state_d = ISSUE;
      end
      (state_q == ISSUE): begin
        if (issue && col_end && row_end && !LOOP_EN)
          state_d = DRAIN;
      end
      (state_q == DRAIN): begin
        if (last_out) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLOCK_50) begin
    if (!RESET_N) begin
      state_q    <= IDLE;
      col_q      <= '0;
      row_q      <= '0;
      addr_q     <= A_BASE;
      inflight_q <= 1'b0;
      tag_q      <= '0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      col_q      <= col_d;
      row_q      <= row_d;
      addr_q     <= addr_d;
      inflight_q <= inflight_d;
      tag_q      <= tag_d;
      done_q     <= done_d;
    end
  end

  assign fifo_wdata = {tag_q, mem_rdata};

  fb_sync_fifo #(
    .DW    (FW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .CLOCK_50 (CLOCK_50),
    .RESET_N  (RESET_N),
    .push     (inflight_q),
    .wdata    (fifo_wdata),
    .pop      (pop),
    .rdata    (fifo_rdata),
    .count    (fifo_count),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  assign {head_tag, pix_data} = fifo_rdata;

  assign pix_valid = !fifo_empty;
  assign pix_sof   = pix_valid && head_tag.sof;
  assign pix_eol   = pix_valid && head_tag.eol;
  assign pix_eof   = pix_valid && head_tag.eof;

  // In loop mode done marks each eof handshake directly.
  assign done = done_q || (LOOP_EN && pop && pix_eof);
  assign busy = (state_q != IDLE);

  assign mem_en    = issue;
  assign mem_addr  = addr_q;
  assign mem_write = 1'b0;
  assign mem_wdata = '0;

endmodule

// File: tb/tb_fb_stream_reader.sv
// Directed bench for fb_stream_reader on a 4x3 frame at base 16.
// RAM model returns the low address byte one cycle after mem_en.
module tb_fb_stream_reader;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        busy;
  logic        done;
  logic [19:0] mem_addr;
  logic        mem_en;
  logic        mem_write;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata = 8'h00;
  logic [7:0]  pix_data;
  logic        pix_valid;
  logic        pix_ready;
  logic        pix_sof;
  logic        pix_eol;
  logic        pix_eof;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  fb_stream_reader #(
    .DATA_WIDTH (8),
    .ADDR_WIDTH (20),
    .WIDTH      (4),
    .HEIGHT     (3),
    .BASE_ADDR  (16),
    .FIFO_DEPTH (4)
  ) dut (
    .CLOCK_50  (clk),
    .RESET_N   (rst_n),
    .start     (start),
    .busy      (busy),
    .done      (done),
    .mem_addr  (mem_addr),
    .mem_en    (mem_en),
    .mem_write (mem_write),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .pix_data  (pix_data),
    .pix_valid (pix_valid),
    .pix_ready (pix_ready),
    .pix_sof   (pix_sof),
    .pix_eol   (pix_eol),
    .pix_eof   (pix_eof)
  );

  always @(posedge clk) begin
    mem_rdata <= mem_en ? mem_addr[7:0] : 8'h00;
  end

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // mode 0: ready=1, 1: 10-cycle stall, 2: random, 3: start while busy
  task automatic run_frame(input int mode);
    int npix;
    int ndone;
    int done_k;
    int stall_iss;
    int maxc;
    int idx;
    npix = 0;
    ndone = 0;
    done_k = 0;
    stall_iss = 0;
    maxc = 0;
    if (mode == 2) void'($urandom(32'd42));
    cyc();
    start = 1'b1;
    cyc();
    start = 1'b0;
    for (int k = 1; k <= 200; k++) begin
      start = (mode == 3 && k == 5);
      unique case (mode)
        1: pix_ready = !(k >= 4 && k <= 13);
        2: pix_ready = 1'($urandom_range(1, 0));
        default: pix_ready = 1'b1;
      endcase
      @(negedge clk);
      if (int'(dut.fifo_count) > maxc) maxc = int'(dut.fifo_count);
      if (mode == 0) begin
        if (k <= 13) chk("issue_en", mem_en, k <= 12);
        if (k <= 12) chk("issue_addr", mem_addr, 15 + k);
        if (k <= 18) chk("valid_run", pix_valid, k >= 3 && k <= 14);
        chk("done_time", done, k == 15);
      end
      if (mode == 1 && k >= 4 && k <= 13) begin
        if (mem_en) stall_iss++;
        chk("stall_valid", pix_valid, 1);
        chk("stall_hold", pix_data, 8'h11);
        if (k == 13) chk("stall_noissue", mem_en, 0);
      end
      if (pix_valid && pix_ready) begin
        idx = npix;
        if (mode == 0) chk("pix_time", k, 3 + idx);
        chk("pix_data", pix_data, 8'h10 + idx);
        chk("pix_sof", pix_sof, idx == 0);
        chk("pix_eol", pix_eol, idx % 4 == 3);
        chk("pix_eof", pix_eof, idx == 11);
        npix++;
      end
      if (done) begin
        ndone++;
        done_k = k;
        chk("busy_at_done", busy, 0);
      end
      if (done_k > 0 && k == done_k + 3) break;
      cyc();
    end
    chk("frame_pixels", npix, 12);
    chk("frame_dones", ndone, 1);
    chk("fifo_max", maxc <= 4, 1);
    chk("mem_write", mem_write, 0);
    if (mode == 1) chk("stall_issues", stall_iss <= 4, 1);
    pix_ready = 1'b1;
    cyc();
  endtask

  initial begin
    int nd;
    int np;
    rst_n = 1'b0;
    start = 1'b0;
    pix_ready = 1'b0;
    repeat (3) cyc();
    @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_mem_en", mem_en, 0);
    chk("rst_valid", pix_valid, 0);
    chk("rst_tags", {pix_sof, pix_eol, pix_eof}, 0);
    chk("rst_data", pix_data, 0);
    chk("rst_addr", mem_addr, 16);
    chk("rst_wdata", mem_wdata, 0);
    cyc();
    rst_n = 1'b1;
    cyc();

`ifdef FB_LOOP_EN
    nd = 0;
    np = 0;
    pix_ready = 1'b1;
    start = 1'b1;
    cyc();
    start = 1'b0;
    for (int k = 1; k <= 38; k++) begin
      @(negedge clk);
      if (k >= 3) begin
        chk("loop_valid", pix_valid, 1);
        chk("loop_data", pix_data, 8'h10 + (k - 3) % 12);
        chk("loop_sof", pix_sof, (k - 3) % 12 == 0);
        chk("loop_eof", pix_eof, (k - 3) % 12 == 11);
        if (pix_valid) np++;
      end
      chk("loop_done", done, k >= 3 && (k - 3) % 12 == 11);
      if (done) nd++;
      cyc();
    end
    chk("loop_pixels", np, 36);
    chk("loop_dones", nd, 3);
    chk("loop_busy", busy, 1);
`else
    run_frame(0);
    run_frame(1);
    run_frame(2);
    run_frame(3);

    pix_ready = 1'b1;
    start = 1'b1;
    cyc();
    start = 1'b0;
    repeat (5) cyc();
    rst_n = 1'b0;
    cyc();
    rst_n = 1'b1;
    @(negedge clk);
    chk("mid_rst_en", mem_en, 0);
    chk("mid_rst_valid", pix_valid, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_done", done, 0);
    nd = 0;
    for (int k = 0; k < 6; k++) begin
      cyc();
      @(negedge clk);
      if (done || mem_en || pix_valid) nd++;
    end
    chk("mid_rst_quiet", nd, 0);
    run_frame(0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
